bs_drvr_fifo: RTL and testbench

- Driver-side buffering stage for one driver port of the parallel-bus generator/arbiter.
- Holds a TX FIFO that the host writes and the arbiter pops through pndng/pop/D_pop.
- Holds an RX FIFO that the arbiter pushes through push/D_push and the host reads.
- One instance per driver per bus; its bus-side ports connect one-to-one to the arbiter's pndng_drvr_X_bus_Y, pop_drvr_X_bus_Y, D_pop_drvr_X_bus_Y, push_drvr_X_bus_Y and D_push_drvr_X_bus_Y.

---
 rtl/bs_pkg.sv | 17 +
 rtl/bs_fifo_fwft.sv | 77 +++++++
 rtl/bs_drvr_fifo.sv | 78 +++++++
 tb/tb_bs_drvr_fifo.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// Shared constants, flag struct and width helper for the driver-side bus FIFOs.
package bs_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

    typedef struct packed {
        logic ovf;
        logic udf;
    } fifo_flags_t;

    // Occupancy counters need one extra bit so a full FIFO (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bs_fifo_fwft.sv
// First-word-fall-through circular FIFO with registered count and sticky overflow/underflow flags.
module bs_fifo_fwft
    import bs_pkg::*;
#(
    parameter int bits  = 32,
    parameter int depth = 16
) (
    input  logic                      clk,
    input  logic                      i_rst_n,
    input  logic                      i_push,
    input  logic [bits-1:0]           i_data,
    input  logic                      i_pop,
    output logic [bits-1:0]           o_data,
    output logic [cnt_w(depth)-1:0]   o_count,
    output fifo_flags_t               o_flags
);

    localparam int PW = $clog2(depth);
    localparam int CW = cnt_w(depth);
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

    logic [bits-1:0] r_mem [depth];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    fifo_flags_t     r_flags;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_flags  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (i_push & ~w_do_push) begin
                r_flags.ovf <= 1'b1;
            end
            if (i_pop & w_empty) begin
                r_flags.udf <= 1'b1;
            end
        end
    end

    // Stale memory is masked so an empty FIFO always presents zero.
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_flags = r_flags;

endmodule

// File: rtl/bs_drvr_fifo.sv
// Driver-side TX/RX buffering for one arbiter port; define BS_DRVR_ID_FILTER_EN to drop RX packets
// whose destination ID is neither drvr_id nor broadcast.
module bs_drvr_fifo
    import bs_pkg::*;
#(
    parameter int              bits      = 32,
    parameter int              depth     = 16,
    parameter logic [ID_W-1:0] drvr_id   = 8'd0,
    parameter logic [ID_W-1:0] broadcast = BCAST_ID
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tx_push,
    input  logic [bits-1:0]         tx_data,
    output logic                    tx_full,
    output logic [cnt_w(depth)-1:0] tx_count,
    output logic                    pndng,
    input  logic                    pop,
    output logic [bits-1:0]         D_pop,
    input  logic                    push,
    input  logic [bits-1:0]         D_push,
    input  logic                    rx_pop,
    output logic [bits-1:0]         rx_data,
    output logic                    rx_empty,
    output logic [cnt_w(depth)-1:0] rx_count,
    output logic [1:0]              ovf,
    output logic [1:0]              udf
);

    localparam int CW = cnt_w(depth);
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

`ifdef BS_DRVR_ID_FILTER_EN
    localparam logic FILTER_BYPASS = 1'b0;
`else
    localparam logic FILTER_BYPASS = 1'b1;
`endif

    logic [ID_W-1:0] w_dest;
    logic            w_id_hit;
    logic            w_rx_push;
    fifo_flags_t     w_tx_flags;
    fifo_flags_t     w_rx_flags;

    assign w_dest    = D_push[bits-1 -: ID_W];
    assign w_id_hit  = (w_dest == drvr_id) | (w_dest == broadcast);
    // Filtered packets never reach the RX FIFO, so they leave count and flags untouched.
    assign w_rx_push = push & (w_id_hit | FILTER_BYPASS);

    bs_fifo_fwft #(.bits(bits), .depth(depth)) u_tx_fifo (
        .clk     (clk),
        .i_rst_n (reset),
        .i_push  (tx_push),
        .i_data  (tx_data),
        .i_pop   (pop),
        .o_data  (D_pop),
        .o_count (tx_count),
        .o_flags (w_tx_flags)
    );

    bs_fifo_fwft #(.bits(bits), .depth(depth)) u_rx_fifo (
        .clk     (clk),
        .i_rst_n (reset),
        .i_push  (w_rx_push),
        .i_data  (D_push),
        .i_pop   (rx_pop),
        .o_data  (rx_data),
        .o_count (rx_count),
        .o_flags (w_rx_flags)
    );

    assign tx_full  = (tx_count == FULL_CNT);
    assign pndng    = (tx_count != '0);
    assign rx_empty = (rx_count == '0);
    assign ovf      = {w_rx_flags.ovf, w_tx_flags.ovf};
    assign udf      = {w_rx_flags.udf, w_tx_flags.udf};

endmodule

// File: tb/tb_bs_drvr_fifo.sv
// Directed plus randomized bench for bs_drvr_fifo against a queue-based reference model.
module tb_bs_drvr_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_push;
    logic [31:0] tx_data;
    logic        tx_full;
    logic [4:0]  tx_count;
    logic        pndng;
    logic        pop;
    logic [31:0] D_pop;
    logic        push;
    logic [31:0] D_push;
    logic        rx_pop;
    logic [31:0] rx_data;
    logic        rx_empty;
    logic [4:0]  rx_count;
    logic [1:0]  ovf;
    logic [1:0]  udf;

    int checks = 0;
    int errors = 0;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic [1:0]  ovf_m;
    logic [1:0]  udf_m;

    bs_drvr_fifo #(.bits(32), .depth(DEPTH), .drvr_id(8'd1), .broadcast(8'hFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_push  (tx_push),
        .tx_data  (tx_data),
        .tx_full  (tx_full),
        .tx_count (tx_count),
        .pndng    (pndng),
        .pop      (pop),
        .D_pop    (D_pop),
        .push     (push),
        .D_push   (D_push),
        .rx_pop   (rx_pop),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rx_count (rx_count),
        .ovf      (ovf),
        .udf      (udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit rx_accepts(input logic [31:0] d);
`ifdef BS_DRVR_ID_FILTER_EN
        return (d[31:24] == 8'h01) || (d[31:24] == 8'hFF);
`else
        return (d[31:24] == d[31:24]);
`endif
    endfunction

    // Behavioural FIFO rules: pop on empty flags udf, push on full without pop flags ovf.
    task automatic model_update(input bit txp, input logic [31:0] txd, input bit pp,
                                input bit rxpush, input logic [31:0] dp, input bit rxp);
        bit taken;
        taken = 1'b0;
        if (pp) begin
            if (tx_q.size() == 0) udf_m[0] = 1'b1;
            else taken = 1'b1;
        end
        if (txp) begin
            if (tx_q.size() < DEPTH || taken) tx_q.push_back(txd);
            else ovf_m[0] = 1'b1;
        end
        if (taken) void'(tx_q.pop_front());

        taken = 1'b0;
        if (rxp) begin
            if (rx_q.size() == 0) udf_m[1] = 1'b1;
            else taken = 1'b1;
        end
        if (rxpush && rx_accepts(dp)) begin
            if (rx_q.size() < DEPTH || taken) rx_q.push_back(dp);
            else ovf_m[1] = 1'b1;
        end
        if (taken) void'(rx_q.pop_front());
    endtask

    task automatic check_all(input string tag);
        check({tag, ".tx_count"}, 64'(tx_count), 64'(tx_q.size()));
        check({tag, ".tx_full"},  64'(tx_full),  64'(tx_q.size() == DEPTH));
        check({tag, ".pndng"},    64'(pndng),    64'(tx_q.size() != 0));
        check({tag, ".D_pop"},    64'(D_pop),    64'((tx_q.size() != 0) ? tx_q[0] : 32'h0));
        check({tag, ".rx_count"}, 64'(rx_count), 64'(rx_q.size()));
        check({tag, ".rx_empty"}, 64'(rx_empty), 64'(rx_q.size() == 0));
        check({tag, ".rx_data"},  64'(rx_data),  64'((rx_q.size() != 0) ? rx_q[0] : 32'h0));
        check({tag, ".ovf"},      64'(ovf),      64'(ovf_m));
        check({tag, ".udf"},      64'(udf),      64'(udf_m));
    endtask

    // Called at a falling edge; drives one cycle of inputs and checks after the next rising edge.
    task automatic step(input string tag, input bit a_txp, input logic [31:0] a_txd, input bit a_pop,
                        input bit a_push, input logic [31:0] a_dp, input bit a_rxp);
        tx_push = a_txp; tx_data = a_txd; pop = a_pop;
        push = a_push; D_push = a_dp; rx_pop = a_rxp;
        @(posedge clk);
        model_update(a_txp, a_txd, a_pop, a_push, a_dp, a_rxp);
        @(negedge clk);
        tx_push = 1'b0; pop = 1'b0; push = 1'b0; rx_pop = 1'b0;
        check_all(tag);
        $display("step %-10s tx_count=%0d rx_count=%0d D_pop=%08h rx_data=%08h ovf=%b udf=%b",
                 tag, tx_count, rx_count, D_pop, rx_data, ovf, udf);
    endtask

    // Reset pulse placed between edges so the clear must be asynchronous.
    task automatic async_reset(input string tag);
        reset = 1'b0;
        #2;
        tx_q.delete(); rx_q.delete(); ovf_m = '0; udf_m = '0;
        check_all({tag, ".async"});
        #2;
        reset = 1'b1;
        @(negedge clk);
        check_all({tag, ".after"});
        $display("reset %-10s tx_count=%0d rx_count=%0d", tag, tx_count, rx_count);
    endtask

    initial begin
        logic [7:0]  ids [3];
        logic [31:0] d;
        int          exp_filt;
        ids = '{8'h01, 8'h02, 8'hFF};
        reset = 1'b0; tx_push = 1'b0; tx_data = '0; pop = 1'b0;
        push = 1'b0; D_push = '0; rx_pop = 1'b0;
        ovf_m = '0; udf_m = '0;

        repeat (3) @(negedge clk);
        check_all("reset");
        reset = 1'b1;
        @(negedge clk);

        for (int i = 1; i <= 16; i++) step("fill", 1'b1, 32'h0100_0000 + 32'(i), 1'b0, 1'b0, '0, 1'b0);
        step("overflow", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, 1'b0);
        step("full_pp", 1'b1, 32'h0300_0003, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check("no_deadbeef", 64'(D_pop == 32'hDEAD_BEEF), 64'(0));
            step("drain", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        end
        step("tx_udf", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

        step("rx_empty_pp", 1'b0, '0, 1'b0, 1'b1, 32'h0100_00AA, 1'b1);
        step("rx_pop1", 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            d = {8'h01, 24'($urandom)};
            step("wrap", 1'b0, '0, 1'b0, 1'b1, d, i != 0);
            check("rx_le1", 64'(rx_count <= 5'd1), 64'(1));
        end
        step("wrap_end", 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            d = {ids[$urandom_range(0, 2)], 24'($urandom)};
            step("random", ($urandom_range(0, 99) < 55), $urandom, ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 55), d, ($urandom_range(0, 99) < 45));
        end

        async_reset("clean");
        for (int i = 0; i < 5; i++) step("pre_tx", 1'b1, 32'h0500_0000 + 32'(i), 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step("pre_rx", 1'b0, '0, 1'b0, 1'b1, 32'h0100_0100 + 32'(i), 1'b0);
        check("pre_tx_count", 64'(tx_count), 64'(5));
        check("pre_rx_count", 64'(rx_count), 64'(3));
        async_reset("midop");
        step("first_push", 1'b1, 32'h0100_0777, 1'b0, 1'b1, 32'h0100_0888, 1'b0);

        async_reset("filt");
        step("filt_a", 1'b0, '0, 1'b0, 1'b1, 32'h0200_0000, 1'b0);
        step("filt_b", 1'b0, '0, 1'b0, 1'b1, 32'h0100_0000, 1'b0);
        step("filt_c", 1'b0, '0, 1'b0, 1'b1, 32'hFF00_0000, 1'b0);
`ifdef BS_DRVR_ID_FILTER_EN
        exp_filt = 2;
`else
        exp_filt = 3;
`endif
        check("filt_rx_count", 64'(rx_count), 64'(exp_filt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
